// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: writeback source select, load funct3 codes and
// the register address width.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension. Purely combinational.
// A halfword at byte offset 3 takes bits [31:16], the same as offset 2;
// misalignment is not trapped here.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to funct3.
    always_comb begin
        unique case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;   // LW and any undefined width
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback mux for the RV32I pipeline.
// Update priority each edge: rst > flush_i > stall_i > capture.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter
// (retire_cnt_o) that counts captures of valid instructions.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int size = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  mem_valid_i,
    input  logic [size-1:0]       mem_alu_result_i,
    input  logic [size-1:0]       mem_rdata_i,
    input  logic [size-1:0]       mem_pc_plus4_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_write_i,
    input  logic [1:0]            mem_wb_sel_i,
    input  logic [2:0]            mem_funct3_i,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]           retire_cnt_o,
`endif
    output logic                  wb_valid_o,
    output logic                  wb_we_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [size-1:0]       wb_data_o
);

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [size-1:0]       alu_q, alu_d;
    logic [size-1:0]       rdata_q, rdata_d;
    logic [size-1:0]       pc4_q, pc4_d;
    logic [1:0]            sel_q, sel_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [size-1:0]       load_data;

    // Next state: flush kills valid/write only, stall holds, otherwise capture.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        sel_d       = sel_q;
        funct3_d    = funct3_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall_i) begin
            valid_d     = mem_valid_i;
            reg_write_d = mem_reg_write_i;
            rd_d        = mem_rd_i;
            alu_d       = mem_alu_result_i;
            rdata_d     = mem_rdata_i;
            pc4_d       = mem_pc_plus4_i;
            sel_d       = mem_wb_sel_i;
            funct3_d    = mem_funct3_i;
        end
    end

    // Pipeline register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            sel_q       <= '0;
            funct3_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
            sel_q       <= sel_d;
            funct3_q    <= funct3_d;
        end
    end

    load_extend u_load_extend (
        .rdata_i  (rdata_q),
        .funct3_i (funct3_q),
        .addr_i   (alu_q[1:0]),
        .data_o   (load_data)
    );

    // Writeback source select; the reserved code falls back to the ALU result.
    always_comb begin
        unique case (sel_q)
            WB_MEM:  wb_data_o = load_data;
            WB_PC4:  wb_data_o = pc4_q;
            default: wb_data_o = alu_q;
        endcase
    end

    assign wb_valid_o = valid_q;
    assign wb_rd_o    = rd_q;
    assign wb_we_o    = valid_q & reg_write_q & (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    // Count only real captures of a valid instruction; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush_i && !stall_i && mem_valid_i)
            cnt_d = cnt_q + 64'd1;
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign retire_cnt_o = cnt_q;
`endif

endmodule
